// File: rtl/regfile_pkg.sv
// Shared constants, types and write-port arbitration for the multi-port
// register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int XLEN_D = 64;
  localparam int NREG_D = 32;
  localparam int NRD_D  = 2;
  localparam int NWR_D  = 2;

  // Upper bound on write ports; hit vectors are sized to this.
  localparam int MAXWR  = 2;

  typedef logic [$clog2(NREG_D)-1:0] reg_addr_t;
  typedef logic [XLEN_D-1:0]         word_t;
  typedef logic [0:0]                wport_t;

  // Given the per-port match vector for one address, return the winning
  // port: the highest-index matching port takes both data and busy-clear.
  function automatic wport_t win_port(input logic [MAXWR-1:0] hit);
    win_port = '0;
    for (int w = 0; w < MAXWR; w++)
      if (hit[w]) win_port = wport_t'(w);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one busy bit per architectural register.
// Priority per register: reset/flush clear, alloc set, winning wr_clr clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int NWR  = NWR_D,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic [NWR-1:0]          wr_clr,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_addr,
  input  logic                    flush,
  output logic [NREG-1:0]         busy,
  output logic                    any_busy
);

  logic [NREG-1:0]  busy_nxt;
  logic [MAXWR-1:0] hit;

  // Next busy vector: clear from the winning write, then alloc overrides,
  // then flush overrides everything. Register 0 is never busy.
  always_comb begin
    busy_nxt = busy;
    hit      = '0;
    for (int r = 1; r < NREG; r++) begin
      hit = '0;
      for (int w = 0; w < NWR; w++)
        hit[w] = wr_en[w] && (wr_addr[w] == AW'(r));
      if ((|hit) && wr_clr[win_port(hit)]) busy_nxt[r] = 1'b0;
      if (alloc_en && (alloc_addr == AW'(r))) busy_nxt[r] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    if (flush) busy_nxt = '0;
  end

  // Busy state register; reset masks all same-cycle updates.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Optional REGFILE_BYPASS_EN: forward same-cycle write data / busy-clear
// to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRD  = NRD_D,
  parameter int NWR  = NWR_D,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic [NWR-1:0]           wr_clr,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  input  logic                     flush,
  output logic                     any_busy
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;

  regfile_scoreboard #(.NREG(NREG), .NWR(NWR)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_clr     (wr_clr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy),
    .any_busy   (any_busy)
  );

  // Data array; later ports overwrite earlier ones so the highest index
  // wins on a collision. Register 0 is never written and stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && (wr_addr[w] != '0)) regs[wr_addr[w]] <= wr_data[w];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [MAXWR-1:0] rhit;
  wport_t           rwin;

  // Read ports with forwarding of the winning same-cycle write.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rhit    = '0;
    rwin    = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
      rhit = '0;
      for (int w = 0; w < NWR; w++)
        rhit[w] = !reset && wr_en[w] && (rd_addr[p] != '0) &&
                  (wr_addr[w] == rd_addr[p]);
      rwin = win_port(rhit);
      if (|rhit) begin
        rd_data[p] = wr_data[rwin];
        if (wr_clr[rwin] && !(alloc_en && (alloc_addr == rd_addr[p])))
          rd_busy[p] = 1'b0;
      end
    end
  end
`else
  // Read ports return stored state only.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;
  import regfile_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0][4:0]      rd_addr;
  logic [1:0][63:0]     rd_data;
  logic [1:0]           rd_busy;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_addr;
  logic [1:0][63:0]     wr_data;
  logic [1:0]           wr_clr;
  logic                 alloc_en;
  logic [4:0]           alloc_addr;
  logic                 flush;
  logic                 any_busy;

  int total = 0;
  int bad   = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_clr(wr_clr), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; idle();
    tick(); tick();
    reset = 1'b0;

    // Reset state across all addresses on both read ports.
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a); rd_addr[1] = 5'(31 - a);
      #1;
      chk($sformatf("rst_data0_x%0d", a), rd_data[0], 64'h0);
      chk($sformatf("rst_data1_x%0d", 31 - a), rd_data[1], 64'h0);
      chk($sformatf("rst_busy_x%0d", a), {62'h0, rd_busy}, 64'h0);
    end
    chk("rst_any_busy", {63'h0, any_busy}, 64'h0);

    // x0 is hardwired to zero.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 64'hDEAD;
    tick(); idle();
    rd_addr[0] = 5'd0; #1;
    chk("x0_zero", rd_data[0], 64'h0);

    // Same-cycle collision: port 1 wins.
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
    wr_data[0] = 64'h1111; wr_data[1] = 64'h2222;
    tick(); idle();
    rd_addr[0] = 5'd5; #1;
    chk("collide_x5", rd_data[0], 64'h2222);

    // Alloc x7: old busy visible in alloc cycle, set after edge.
    alloc_en = 1'b1; alloc_addr = 5'd7; rd_addr[0] = 5'd7; #1;
    chk("alloc_cycle_busy_old", {63'h0, rd_busy[0]}, 64'h0);
    tick(); idle(); #1;
    chk("alloc_x7_busy", {63'h0, rd_busy[0]}, 64'h1);
    chk("alloc_any_busy", {63'h0, any_busy}, 64'h1);
    wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 64'h42; wr_clr[0] = 1'b1;
    tick(); idle(); #1;
    chk("clr_x7_data", rd_data[0], 64'h42);
    chk("clr_x7_busy", {63'h0, rd_busy[0]}, 64'h0);
    chk("clr_any_busy", {63'h0, any_busy}, 64'h0);

    // Collision with differing wr_clr: port 1 (clr=0) wins, busy stays.
    alloc_en = 1'b1; alloc_addr = 5'd8;
    tick(); idle();
    wr_en = 2'b11; wr_addr[0] = 5'd8; wr_addr[1] = 5'd8;
    wr_data[0] = 64'h7777; wr_data[1] = 64'h8888; wr_clr = 2'b01;
    tick(); idle();
    rd_addr[0] = 5'd8; #1;
    chk("prio_x8_data", rd_data[0], 64'h8888);
    chk("prio_x8_busy", {63'h0, rd_busy[0]}, 64'h1);
    wr_en = 2'b11; wr_addr[0] = 5'd8; wr_addr[1] = 5'd8; wr_clr = 2'b10;
    wr_data[0] = 64'h1; wr_data[1] = 64'h2;
    tick(); idle(); #1;
    chk("prio_x8_clr_busy", {63'h0, rd_busy[0]}, 64'h0);

    // Alloc beats same-cycle wr_clr.
    alloc_en = 1'b1; alloc_addr = 5'd9;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 64'h99; wr_clr[0] = 1'b1;
    tick(); idle();
    rd_addr[0] = 5'd9; #1;
    chk("alloc_vs_clr_busy", {63'h0, rd_busy[0]}, 64'h1);
    chk("alloc_vs_clr_data", rd_data[0], 64'h99);

    // Flush beats alloc; data untouched.
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd10;
    tick(); idle();
    rd_addr[0] = 5'd10; rd_addr[1] = 5'd9; #1;
    chk("flush_x10_busy", {63'h0, rd_busy[0]}, 64'h0);
    chk("flush_x9_busy", {63'h0, rd_busy[1]}, 64'h0);
    chk("flush_any_busy", {63'h0, any_busy}, 64'h0);
    chk("flush_x9_data", rd_data[1], 64'h99);

    // Alloc to x0 dropped.
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick(); idle();
    rd_addr[0] = 5'd0; #1;
    chk("alloc_x0_busy", {63'h0, rd_busy[0]}, 64'h0);
    chk("alloc_x0_any", {63'h0, any_busy}, 64'h0);

    // Same-cycle read of a register being written.
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick(); idle();
    rd_addr[1] = 5'd3;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 64'hABCD; wr_clr[0] = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_data", rd_data[1], 64'hABCD);
    chk("bypass_same_busy", {63'h0, rd_busy[1]}, 64'h0);
`else
    chk("nobypass_same_data", rd_data[1], 64'h0);
    chk("nobypass_same_busy", {63'h0, rd_busy[1]}, 64'h1);
`endif
    tick(); idle(); #1;
    chk("write_next_data", rd_data[1], 64'hABCD);
    chk("write_next_busy", {63'h0, rd_busy[1]}, 64'h0);

    // Reset in the middle of activity.
    alloc_en = 1'b1; alloc_addr = 5'd12;
    tick(); idle();
    reset = 1'b1;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd13; wr_data[0] = 64'h77; wr_clr[0] = 1'b1;
    alloc_en = 1'b1; alloc_addr = 5'd14;
    rd_addr[0] = 5'd13; #1;
    chk("reset_no_bypass", rd_data[0], 64'h0);
    tick(); reset = 1'b0; idle();
    rd_addr[0] = 5'd13; rd_addr[1] = 5'd5; #1;
    chk("mid_rst_x13_data", rd_data[0], 64'h0);
    chk("mid_rst_x5_data", rd_data[1], 64'h0);
    rd_addr[0] = 5'd12; rd_addr[1] = 5'd14; #1;
    chk("mid_rst_busy", {62'h0, rd_busy}, 64'h0);
    chk("mid_rst_any", {63'h0, any_busy}, 64'h0);
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd9; #1;
    chk("mid_rst_x3_data", rd_data[0], 64'h0);
    chk("mid_rst_x9_data", rd_data[1], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, replacing the single-write, two-read register file in the core's decode/writeback path. It provides NRD combinational read ports and NWR synchronous write ports with fixed port priority, and tracks one busy bit per architectural register for hazard detection. Optionally, same-cycle write data is forwarded to the read ports.

## Interface
Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of registers; power of two, ≥ 2.
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..2.
- AW, $clog2(NREG), address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD×AW  read addresses.
- rd_data  out  NRD×XLEN  read data, combinational.
- rd_busy  out  NRD  busy bit of the addressed register, combinational.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR×AW  write addresses.
- wr_data  in  NWR×XLEN  write data.
- wr_clr  in  NWR  when set with wr_en, also clear the target's busy bit.
- alloc_en  in  1  mark alloc_addr busy (new in-flight producer).
- alloc_addr  in  AW  register to allocate.
- flush  in  1  clear all busy bits (pipeline flush); register data is untouched.
- any_busy  out  1  OR of all busy bits, registered state.

## Operation
- Register 0 is hardwired to zero and is never busy. Writes and allocations to address 0 are dropped.
- Write priority: if both write ports target the same nonzero address, port NWR-1 (highest index) wins for both data and busy-clear.
- Busy update per register, in priority order:
  - reset, or flush: cleared.
  - alloc_en to this register: set. Allocation wins over a same-cycle wr_clr, because the new producer supersedes the retiring one.
  - wr_en && wr_clr to this register: cleared.
  - Otherwise: held.
- A write with wr_clr = 0 updates data only; busy is unchanged.
- While reset is high, all writes, allocations and flushes are ignored. After the reset edge, all data and busy bits are 0.
- rd_data and rd_busy reflect stored state, modified only as described under Configuration.
- any_busy is the OR of the stored busy bits. It reads 0 after reset and in the cycle after a flush.

## Timing
- Write latency is 1 cycle: data written at edge N is visible on rd_data after edge N (without bypass).
- Busy set/clear takes effect at the next edge. rd_busy in the alloc cycle still shows the old value.
- No handshakes. Every port is accepted every cycle; there is no backpressure.
- Reset values: every register 0, every busy bit 0, any_busy 0. rd_data and rd_busy therefore read 0 for any address.
- Flush and alloc in the same cycle: flush wins, so the allocated register ends up not busy.

## Configuration
- REGFILE_BYPASS_EN defined:
  - For each read port, if any wr_en targets the same nonzero rd_addr this cycle, rd_data returns the winning port's wr_data (write priority applies).
  - rd_busy returns 0 for that port when the winning write has wr_clr set and there is no same-cycle alloc to that address.
  - Reads of address 0 always return 0.
  - Bypass is disabled while reset is high.
- REGFILE_BYPASS_EN undefined: reads return stored state only. There is no combinational path from the wr_* inputs to rd_data.

## Structure
- Shared package regfile_pkg holds:
  - the default constants (XLEN, NREG, NRD, NWR);
  - typedefs reg_addr_t and word_t;
  - a function that resolves the winning write port for a given address.
- One sub-module, regfile_scoreboard, holds the busy vector, the alloc/clear/flush logic and any_busy. The data array and bypass muxing live in regfile_mp.

## Test plan
- Reset then read all addresses -> rd_data 0, rd_busy 0, any_busy 0. Write x0 = 64'hDEAD on port 0 -> x0 still reads 0.
- Same-cycle writes: port 0 x5 = 64'h1111 and port 1 x5 = 64'h2222 -> next cycle x5 reads 64'h2222.
- alloc x7 -> next cycle rd_busy 1, any_busy 1. Write x7 = 64'h42 with wr_clr -> next cycle data 64'h42, busy 0, any_busy 0.
- alloc x9 together with a wr_clr write to x9 in the same cycle -> x9 busy afterwards and data updated. Alloc x9 together with flush -> x9 not busy.
- With REGFILE_BYPASS_EN defined: read x3 while writing x3 = 64'hABCD in the same cycle -> rd_data 64'hABCD that cycle. Without the macro -> old value that cycle, 64'hABCD the next.
- Assert reset in the middle of a sequence of writes and allocs -> all data and busy bits 0 after the edge; same-cycle writes are dropped.
